// File: rtl/button_pkg.sv
// Shared state encoding and default 50 MHz timing constants for the button
// press classifier and its timer.
package button_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        HELD   = 3'd4
    } state_e;

    localparam int unsigned DEF_LONG_CYCLES   = 50_000_000;  // 1.0 s
    localparam int unsigned DEF_GAP_CYCLES    = 12_500_000;  // 250 ms
    localparam int unsigned DEF_REPEAT_CYCLES = 5_000_000;   // 100 ms
    localparam int unsigned DEF_CNT_W         = 26;

endpackage

// File: rtl/press_timer.sv
// Loadable up-counter with a terminal-compare hit flag; the classifier FSM
// picks the terminal value for whichever phase it is timing.
module press_timer #(
    parameter int unsigned CNT_W = 26
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             hit_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= ONE;
        end else if (inc_i) begin
            cnt_q <= cnt_q + ONE;
        end
    end

    assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/button_press_classifier.sv
// Classifies debounced button gestures into short / long / double press pulses.
// Define BUTTON_PRESS_CLASSIFIER_AUTO_REPEAT_EN to get repeat pulses while held.
module button_press_classifier
    import button_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic clr_n,
    input  logic btn_level,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic repeat_press,
    output logic busy
);

    localparam logic [CNT_W-1:0] LONG_T = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_T  = CNT_W'(GAP_CYCLES - 1);
    // HELD is entered with cnt=1 on the long-press sample itself, so the
    // terminal value here is the full period rather than period-1.
    localparam logic [CNT_W-1:0] REP_T  = CNT_W'(REPEAT_CYCLES);

    state_e           state_q, state_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             double_q, double_d;
    logic             rep_q, rep_d;
    logic             busy_q;
    logic             load, inc, hit;
    logic [CNT_W-1:0] term;

    press_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .clr_n  (clr_n),
        .load_i (load),
        .inc_i  (inc),
        .term_i (term),
        .hit_o  (hit)
    );

    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        rep_d    = 1'b0;
        load     = 1'b0;
        inc      = 1'b0;
        unique case (state_q)
            PRESS1:  term = LONG_T;
            WAIT2:   term = GAP_T;
            default: term = REP_T;
        endcase

        case (state_q)
            IDLE: begin
                if (btn_level) begin
                    state_d = PRESS1;
                    load    = 1'b1;
                end
            end
            PRESS1: begin
                if (!btn_level) begin
                    state_d = WAIT2;
                    load    = 1'b1;
                end else if (hit) begin
                    long_d  = 1'b1;
                    state_d = HELD;
                    load    = 1'b1;
                end else begin
                    inc = 1'b1;
                end
            end
            WAIT2: begin
                if (btn_level) begin
                    state_d = PRESS2;
                end else if (hit) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    inc = 1'b1;
                end
            end
            PRESS2: begin
                if (!btn_level) begin
                    double_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            HELD: begin
                if (!btn_level) begin
                    state_d = IDLE;
                end else begin
`ifdef BUTTON_PRESS_CLASSIFIER_AUTO_REPEAT_EN
                    if (hit) begin
                        rep_d = 1'b1;
                        load  = 1'b1;
                    end else begin
                        inc = 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= IDLE;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            rep_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
            rep_q    <= rep_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_press = double_q;
    assign busy         = busy_q;
`ifdef BUTTON_PRESS_CLASSIFIER_AUTO_REPEAT_EN
    assign repeat_press = rep_q;
`else
    assign repeat_press = 1'b0;
`endif

endmodule
